flex_counter_mc: RTL and testbench

Multi-channel, parametrised flex counter that runs NUM_CH independent counters of NUM_CNT_BITS each. Each channel has its own per-channel up/down direction, wrap or one-shot mode, synchronous load and a runtime rollover value. It serves as the shared timing and event-count resource for the datapath controllers (bit-period timers, byte counters, timeout watchdogs) and replaces per-client single-channel counters. All outputs are registered.

---
 rtl/flex_counter_pkg.sv | 16 +
 rtl/flex_counter_ch.sv | 78 +++++++
 rtl/flex_counter_mc.sv | 40 ++++
 tb/tb_flex_counter_mc.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flex_counter_pkg.sv
// Shared types and constants for the multi-channel flex counter.
// Mode encoding: bit0 selects direction, bit1 selects one-shot.
package flex_counter_pkg;

   typedef enum logic [1:0] {
      UP_WRAP      = 2'b00,
      DOWN_WRAP    = 2'b01,
      UP_ONESHOT   = 2'b10,
      DOWN_ONESHOT = 2'b11
   } mode_t;

   localparam int MODE_W      = 2;
   localparam int DIR_BIT     = 0;
   localparam int ONESHOT_BIT = 1;

endpackage

// File: rtl/flex_counter_ch.sv
// One flex counter channel: up/down, wrap/one-shot, load and clear.
// All outputs come straight from flops.
module flex_counter_ch
   import flex_counter_pkg::*;
#(
   parameter int NUM_CNT_BITS = 8
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    load,
   input  logic                    count_enable,
   input  logic [MODE_W-1:0]       mode,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   input  logic [NUM_CNT_BITS-1:0] load_val,
   output logic [NUM_CNT_BITS-1:0] count_out,
   output logic                    rollover_flag,
   output logic                    wrap_pulse
);

   localparam logic [NUM_CNT_BITS-1:0] ONE = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

   logic                    dir_down;
   logic                    one_shot;
   logic                    stopped;
   logic                    step_wrap;
   logic [NUM_CNT_BITS-1:0] term;
   logic [NUM_CNT_BITS-1:0] step_cnt;

   always_comb begin
      dir_down  = mode[DIR_BIT];
      one_shot  = mode[ONESHOT_BIT];
      term      = dir_down ? '0 : rollover_val;
      stopped   = one_shot && rollover_flag && (count_out == term);
      step_cnt  = count_out;
      step_wrap = 1'b0;
      // R of zero pins the count at zero; not treated as a wrap
      if (rollover_val == '0) begin
         step_cnt = '0;
      end else if (!dir_down) begin
         if (count_out < rollover_val) begin
            step_cnt = count_out + ONE;
         end else begin
            step_cnt  = ONE;
            step_wrap = 1'b1;
         end
      end else begin
         if (count_out != '0) begin
            step_cnt = count_out - ONE;
         end else begin
            step_cnt  = rollover_val;
            step_wrap = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_out     <= '0;
         rollover_flag <= 1'b0;
         wrap_pulse    <= 1'b0;
      end else begin
         wrap_pulse <= 1'b0;
         if (clear) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
         end else if (load) begin
            count_out     <= load_val;
            rollover_flag <= (load_val == term);
         end else if (count_enable && !stopped) begin
            count_out     <= step_cnt;
            rollover_flag <= (step_cnt == term);
            wrap_pulse    <= step_wrap && !one_shot;
         end
      end
   end

endmodule

// File: rtl/flex_counter_mc.sv
// NUM_CH independent flex counter channels behind packed vector ports.
// Channel i owns slice [i*NUM_CNT_BITS +: NUM_CNT_BITS] and bit [i].
module flex_counter_mc
   import flex_counter_pkg::*;
#(
   parameter int NUM_CNT_BITS = 8,
   parameter int NUM_CH       = 4
) (
   input  logic                           clk,
   input  logic                           n_rst,
   input  logic [NUM_CH-1:0]              clear,
   input  logic [NUM_CH-1:0]              load,
   input  logic [NUM_CH-1:0]              count_enable,
   input  logic [MODE_W*NUM_CH-1:0]       mode,
   input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
   input  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val,
   output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
   output logic [NUM_CH-1:0]              rollover_flag,
   output logic [NUM_CH-1:0]              wrap_pulse
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      flex_counter_ch #(
         .NUM_CNT_BITS(NUM_CNT_BITS)
      ) u_ch (
         .clk          (clk),
         .n_rst        (n_rst),
         .clear        (clear[i]),
         .load         (load[i]),
         .count_enable (count_enable[i]),
         .mode         (mode[i*MODE_W +: MODE_W]),
         .rollover_val (rollover_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
         .load_val     (load_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
         .count_out    (count_out[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
         .rollover_flag(rollover_flag[i]),
         .wrap_pulse   (wrap_pulse[i])
      );
   end

endmodule

// File: tb/tb_flex_counter_mc.sv
// Bench for flex_counter_mc: directed scenarios plus randomized traffic
// checked against an integer model of the channel rules.
module tb_flex_counter_mc;
   import flex_counter_pkg::*;

   localparam int W  = 8;
   localparam int NC = 4;

   logic            clk;
   logic            n_rst;
   logic [NC-1:0]   clear;
   logic [NC-1:0]   load;
   logic [NC-1:0]   count_enable;
   logic [2*NC-1:0] mode;
   logic [NC*W-1:0] rollover_val;
   logic [NC*W-1:0] load_val;
   logic [NC*W-1:0] count_out;
   logic [NC-1:0]   rollover_flag;
   logic [NC-1:0]   wrap_pulse;

   int n_cmp;
   int n_err;
   int m_cnt  [NC];
   int m_flag [NC];
   int m_wp   [NC];

   flex_counter_mc #(.NUM_CNT_BITS(W), .NUM_CH(NC)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (clear),
      .load         (load),
      .count_enable (count_enable),
      .mode         (mode),
      .rollover_val (rollover_val),
      .load_val     (load_val),
      .count_out    (count_out),
      .rollover_flag(rollover_flag),
      .wrap_pulse   (wrap_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < NC; i++) begin
         m_cnt[i] = 0; m_flag[i] = 0; m_wp[i] = 0;
      end
   endtask

   // Integer model of the per-channel rules, applied at each rising edge
   task automatic model_step();
      for (int i = 0; i < NC; i++) begin
         int r, t, c;
         bit dn, os, wr;
         r  = int'(rollover_val[i*W +: W]);
         dn = mode[2*i+DIR_BIT];
         os = mode[2*i+ONESHOT_BIT];
         t  = dn ? 0 : r;
         c  = m_cnt[i];
         wr = 1'b0;
         if (clear[i]) begin
            m_cnt[i] = 0; m_flag[i] = 0; m_wp[i] = 0;
         end else if (load[i]) begin
            m_cnt[i] = int'(load_val[i*W +: W]);
            m_flag[i] = (m_cnt[i] == t); m_wp[i] = 0;
         end else if (count_enable[i] && !(os && m_flag[i] != 0 && c == t)) begin
            if (r == 0) c = 0;
            else if (!dn) begin
               if (c < r) c = c + 1;
               else begin c = 1; wr = 1'b1; end
            end else begin
               if (c > 0) c = c - 1;
               else begin c = r; wr = 1'b1; end
            end
            m_cnt[i] = c; m_flag[i] = (c == t); m_wp[i] = (wr && !os);
         end else begin
            m_wp[i] = 0;
         end
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int i, input mode_t md, input int r, input int lv);
      mode[2*i +: 2]         = md;
      rollover_val[i*W +: W] = W'(r);
      load_val[i*W +: W]     = W'(lv);
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      model_reset();
      #2;
      n_cmp++;
      if (count_out !== '0 || rollover_flag !== '0 || wrap_pulse !== '0) begin
         n_err++;
         $display("FAIL reset: cnt=%h flag=%b wp=%b, want all zero",
                  count_out, rollover_flag, wrap_pulse);
      end
      @(negedge clk);
      n_rst = 1'b1;
   endtask

   task automatic test_up_wrap();
      int ec, ef, ew;
      set_ch(0, UP_WRAP, 5, 0);
      count_enable[0] = 1'b1;
      for (int k = 0; k < 12; k++) begin
         cycle();
         ec = (k % 5) + 1;
         ef = (ec == 5);
         ew = (ec == 1 && k > 0);
         n_cmp++;
         if (count_out[0 +: W] !== W'(ec) || rollover_flag[0] !== ef[0] ||
             wrap_pulse[0] !== ew[0]) begin
            n_err++;
            $display("FAIL up_wrap k=%0d: cnt=%0d flag=%b wp=%b, want %0d %0d %0d",
                     k, count_out[0 +: W], rollover_flag[0], wrap_pulse[0], ec, ef, ew);
         end
      end
      count_enable[0] = 1'b0;
   endtask

   task automatic test_down_wrap();
      int ec;
      set_ch(1, DOWN_WRAP, 6, 3);
      load[1] = 1'b1;
      cycle();
      load[1] = 1'b0;
      n_cmp++;
      if (count_out[W +: W] !== 8'd3 || rollover_flag[1] !== 1'b0) begin
         n_err++;
         $display("FAIL down_load: cnt=%0d flag=%b, want 3 0",
                  count_out[W +: W], rollover_flag[1]);
      end
      count_enable[1] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cycle();
         ec = (k < 3) ? 2 - k : (k == 3 ? 6 : 5);
         n_cmp++;
         if (count_out[W +: W] !== W'(ec) || rollover_flag[1] !== (ec == 0) ||
             wrap_pulse[1] !== (k == 3)) begin
            n_err++;
            $display("FAIL down_wrap k=%0d: cnt=%0d flag=%b wp=%b, want cnt=%0d",
                     k, count_out[W +: W], rollover_flag[1], wrap_pulse[1], ec);
         end
      end
      count_enable[1] = 1'b0;
   endtask

   task automatic test_oneshot();
      int ec;
      set_ch(2, UP_ONESHOT, 3, 0);
      count_enable[2] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cycle();
         ec = (k < 3) ? k + 1 : 3;
         n_cmp++;
         if (count_out[2*W +: W] !== W'(ec) || rollover_flag[2] !== (ec == 3) ||
             wrap_pulse[2] !== 1'b0) begin
            n_err++;
            $display("FAIL oneshot k=%0d: cnt=%0d flag=%b wp=%b, want cnt=%0d",
                     k, count_out[2*W +: W], rollover_flag[2], wrap_pulse[2], ec);
         end
      end
      load[2] = 1'b1;
      cycle();
      load[2] = 1'b0;
      n_cmp++;
      if (count_out[2*W +: W] !== 8'd0 || rollover_flag[2] !== 1'b0) begin
         n_err++;
         $display("FAIL oneshot_rearm: cnt=%0d flag=%b, want 0 0",
                  count_out[2*W +: W], rollover_flag[2]);
      end
      cycle();
      n_cmp++;
      if (count_out[2*W +: W] !== 8'd1) begin
         n_err++;
         $display("FAIL oneshot_resume: cnt=%0d, want 1", count_out[2*W +: W]);
      end
      count_enable[2] = 1'b0;
   endtask

   task automatic test_priority();
      set_ch(3, UP_WRAP, 9, 7);
      load[3] = 1'b1;
      cycle();
      load_val[3*W +: W] = 8'd5;
      clear[3] = 1'b1;
      count_enable[3] = 1'b1;
      count_enable[0] = 1'b1;
      cycle();
      n_cmp++;
      if (count_out[3*W +: W] !== 8'd0 || rollover_flag[3] !== 1'b0 ||
          wrap_pulse[3] !== 1'b0) begin
         n_err++;
         $display("FAIL prio_clear: cnt=%0d flag=%b wp=%b, want 0 0 0",
                  count_out[3*W +: W], rollover_flag[3], wrap_pulse[3]);
      end
      n_cmp++;
      if (count_out[0 +: W] !== W'(m_cnt[0]) || rollover_flag[0] !== m_flag[0][0] ||
          wrap_pulse[0] !== m_wp[0][0]) begin
         n_err++;
         $display("FAIL prio_indep: ch0 cnt=%0d flag=%b wp=%b, want %0d %0d %0d",
                  count_out[0 +: W], rollover_flag[0], wrap_pulse[0],
                  m_cnt[0], m_flag[0], m_wp[0]);
      end
      clear[3] = 1'b0;
      count_enable[0] = 1'b0;
      cycle();
      n_cmp++;
      if (count_out[3*W +: W] !== 8'd5 || rollover_flag[3] !== 1'b0) begin
         n_err++;
         $display("FAIL prio_load: cnt=%0d flag=%b, want 5 0",
                  count_out[3*W +: W], rollover_flag[3]);
      end
      load[3] = 1'b0;
      count_enable[3] = 1'b0;
   endtask

   task automatic test_boundaries();
      set_ch(0, UP_WRAP, 0, 0);
      count_enable[0] = 1'b1;
      for (int k = 0; k < 2; k++) begin
         cycle();
         n_cmp++;
         if (count_out[0 +: W] !== 8'd0 || rollover_flag[0] !== 1'b1 ||
             wrap_pulse[0] !== 1'b0) begin
            n_err++;
            $display("FAIL r_zero k=%0d: cnt=%0d flag=%b wp=%b, want 0 1 0",
                     k, count_out[0 +: W], rollover_flag[0], wrap_pulse[0]);
         end
      end
      count_enable[0] = 1'b0;
      set_ch(1, UP_WRAP, 20, 9);
      load[1] = 1'b1;
      cycle();
      load[1] = 1'b0;
      rollover_val[W +: W] = 8'd4;
      count_enable[1] = 1'b1;
      cycle();
      count_enable[1] = 1'b0;
      n_cmp++;
      if (count_out[W +: W] !== 8'd1 || wrap_pulse[1] !== 1'b1 ||
          rollover_flag[1] !== 1'b0) begin
         n_err++;
         $display("FAIL r_lowered: cnt=%0d flag=%b wp=%b, want 1 0 1",
                  count_out[W +: W], rollover_flag[1], wrap_pulse[1]);
      end
      set_ch(2, UP_WRAP, 255, 253);
      load[2] = 1'b1;
      cycle();
      load[2] = 1'b0;
      count_enable[2] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         int ec;
         cycle();
         ec = (k == 0) ? 254 : (k == 1 ? 255 : 1);
         n_cmp++;
         if (count_out[2*W +: W] !== W'(ec) || rollover_flag[2] !== (ec == 255) ||
             wrap_pulse[2] !== (k == 2)) begin
            n_err++;
            $display("FAIL r_max k=%0d: cnt=%0d flag=%b wp=%b, want cnt=%0d",
                     k, count_out[2*W +: W], rollover_flag[2], wrap_pulse[2], ec);
         end
      end
      count_enable[2] = 1'b0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NC; i++) begin
            clear[i]        = ($urandom % 20) == 0;
            load[i]         = ($urandom % 10) == 0;
            count_enable[i] = ($urandom % 4) != 0;
            if (($urandom % 16) == 0) mode[2*i +: 2] = 2'($urandom);
            if (($urandom % 16) == 0)
               rollover_val[i*W +: W] = (($urandom % 8) == 0) ? W'($urandom)
                                                             : W'($urandom_range(0, 9));
            load_val[i*W +: W] = W'($urandom_range(0, 12));
         end
         cycle();
         for (int i = 0; i < NC; i++) begin
            n_cmp++;
            if (count_out[i*W +: W] !== W'(m_cnt[i]) ||
                rollover_flag[i] !== m_flag[i][0] || wrap_pulse[i] !== m_wp[i][0]) begin
               n_err++;
               $display("FAIL random n=%0d ch=%0d: cnt=%0d flag=%b wp=%b, want %0d %0d %0d",
                        n, i, count_out[i*W +: W], rollover_flag[i], wrap_pulse[i],
                        m_cnt[i], m_flag[i], m_wp[i]);
            end
         end
      end
      clear = '0; load = '0; count_enable = '0;
   endtask

   task automatic test_async_reset();
      set_ch(0, UP_WRAP, 10, 0);
      clear[0] = 1'b1;
      cycle();
      clear[0] = 1'b0;
      count_enable[0] = 1'b1;
      repeat (4) cycle();
      n_cmp++;
      if (count_out[0 +: W] !== 8'd4) begin
         n_err++;
         $display("FAIL pre_reset: cnt=%0d, want 4", count_out[0 +: W]);
      end
      #2;
      n_rst = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if (count_out !== '0 || rollover_flag !== '0 || wrap_pulse !== '0) begin
         n_err++;
         $display("FAIL async_reset: cnt=%h flag=%b wp=%b, want all zero",
                  count_out, rollover_flag, wrap_pulse);
      end
      #1;
      n_rst = 1'b1;
      cycle();
      n_cmp++;
      if (count_out[0 +: W] !== 8'd1 || rollover_flag[0] !== 1'b0) begin
         n_err++;
         $display("FAIL post_reset: cnt=%0d flag=%b, want 1 0",
                  count_out[0 +: W], rollover_flag[0]);
      end
      count_enable[0] = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      clear = '0;
      load = '0;
      count_enable = '0;
      mode = '0;
      rollover_val = '0;
      load_val = '0;
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_oneshot();
      test_priority();
      test_boundaries();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
